// File: rtl/run_controller.sv
// ---------------------------------------------------------------------------
// run_controller
// Drives a Hack-style Computer through reset -> run -> halt, then snapshots
// NWATCH data-memory words through a one-cycle-latency read port.
//
// Optional feature macro: RUNCTL_HALT_DETECT_EN
//   defined     : a run ends when pc stays unchanged for HALT_WINDOW cycles
//                 or when the MAX_CYCLES budget is used up (halt wins a tie).
//   not defined : no stable counter; a run always ends on MAX_CYCLES and
//                 reports timeout.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle run request (honoured in IDLE and DONE)
//   pc           in   CPU program counter
//   cpu_reset    out  active-high reset to the CPU
//   cpu_run      out  CPU clock enable
//   mem_rd       out  data-memory read strobe
//   mem_addr     out  data-memory read address
//   mem_rdata    in   read data, valid one cycle after mem_rd
//   busy         out  RESET, RUN or DUMP in progress
//   done         out  run and snapshot finished
//   timeout      out  run ended on the cycle budget
//   cycles       out  RUN cycles executed (saturating)
//   watch_data   out  snapshot, word i at [i*DATA_W +: DATA_W]
//   watch_valid  out  snapshot complete
// ---------------------------------------------------------------------------
module run_controller #(
   parameter int                       ADDR_W       = 15,
   parameter int                       DATA_W       = 16,
   parameter int                       PC_W         = 15,
   parameter int                       NWATCH       = 4,
   parameter logic [NWATCH*ADDR_W-1:0] WATCH_ADDRS  = {15'd16, 15'd2, 15'd1, 15'd0},
   parameter int                       RESET_CYCLES = 4,
   parameter int                       MAX_CYCLES   = 250,
   parameter int                       HALT_WINDOW  = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [PC_W-1:0]          pc,
   output logic                     cpu_reset,
   output logic                     cpu_run,
   output logic                     mem_rd,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [31:0]              cycles,
   output logic [NWATCH*DATA_W-1:0] watch_data,
   output logic                     watch_valid
);

   localparam int IDX_W = $clog2(NWATCH + 1);
   localparam int RST_W = $clog2(RESET_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RESET  = 3'd1,
      RUN    = 3'd2,
      DUMP   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [RST_W-1:0]  rst_cnt;
   logic [IDX_W-1:0]  rd_cnt;
   logic              rd_vld_p1;
   logic [IDX_W-1:0]  rd_idx_p1;
   logic [31:0]       cycles_nxt;
   logic              start_run;
   logic              timeout_hit;
   logic              halt_hit;

`ifdef RUNCTL_HALT_DETECT_EN
   localparam int STB_W = $clog2(HALT_WINDOW + 1);
   logic [PC_W-1:0]   pc_prev;
   logic              pc_prev_vld;
   logic [STB_W-1:0]  stable_cnt;
   logic [STB_W-1:0]  stable_nxt;

   // The first RUN cycle has no previous pc, so it counts as a change.
   always_comb begin
      stable_nxt = '0;
      if (pc_prev_vld && (pc == pc_prev))
         stable_nxt = stable_cnt + 1'b1;
   end

   assign halt_hit = (state == RUN) && (stable_nxt == STB_W'(HALT_WINDOW - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_prev     <= '0;
         pc_prev_vld <= 1'b0;
         stable_cnt  <= '0;
      end else if (start_run) begin
         pc_prev_vld <= 1'b0;
         stable_cnt  <= '0;
      end else if (state == RUN) begin
         pc_prev     <= pc;
         pc_prev_vld <= 1'b1;
         stable_cnt  <= stable_nxt;
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^pc;
   assign halt_hit  = 1'b0;
`endif

   assign start_run   = start && ((state == IDLE) || (state == DONE));
   assign cycles_nxt  = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
   assign timeout_hit = (state == RUN) && (cycles_nxt == 32'(MAX_CYCLES));

   // Outputs decode registered state only; no input reaches an output
   // combinationally.
   assign cpu_reset   = (state == IDLE) || (state == RESET);
   assign cpu_run     = (state == RESET) || (state == RUN);
   assign busy        = (state == RESET) || (state == RUN) || (state == DUMP);
   assign done        = (state == DONE);
   assign watch_valid = (state == DONE);
   assign mem_rd      = (state == DUMP) && (rd_cnt < IDX_W'(NWATCH));

   always_comb begin
      mem_addr = '0;
      if (mem_rd) begin
         for (int i = 0; i < NWATCH; i++) begin
            if (rd_cnt == IDX_W'(i))
               mem_addr = WATCH_ADDRS[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RESET;
         RESET:   if (rst_cnt == RST_W'(RESET_CYCLES - 1)) next_state = RUN;
         RUN:     if (halt_hit || timeout_hit) next_state = DUMP;
         // DUMP ends on the edge that captures the last returned word.
         DUMP:    if (rd_vld_p1 && (rd_idx_p1 == IDX_W'(NWATCH - 1))) next_state = DONE;
         DONE:    if (start) next_state = RESET;
         default: next_state = IDLE;
      endcase
   end

   // Run bookkeeping: reset hold count, cycle budget, timeout flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rst_cnt <= '0;
         cycles  <= '0;
         timeout <= 1'b0;
         rd_cnt  <= '0;
      end else if (start_run) begin
         rst_cnt <= '0;
         cycles  <= '0;
         timeout <= 1'b0;
         rd_cnt  <= '0;
      end else begin
         if (state == RESET)
            rst_cnt <= rst_cnt + 1'b1;
         if (state == RUN) begin
            cycles <= cycles_nxt;
            if (timeout_hit && !halt_hit)
               timeout <= 1'b1;
         end
         if (mem_rd)
            rd_cnt <= rd_cnt + 1'b1;
      end
   end

   // p0 -> p1: read issued this cycle, its data arrives next cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_vld_p1 <= 1'b0;
         rd_idx_p1 <= '0;
      end else begin
         rd_vld_p1 <= mem_rd;
         rd_idx_p1 <= rd_cnt;
      end
   end

   // p1 capture: returned word lands in its snapshot slot.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         watch_data <= '0;
      end else if (rd_vld_p1) begin
         for (int i = 0; i < NWATCH; i++) begin
            if (rd_idx_p1 == IDX_W'(i))
               watch_data[i*DATA_W +: DATA_W] <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;

   logic        clock;
   logic        reset;
   logic        start;
   logic [14:0] pc;
   logic        cpu_reset;
   logic        cpu_run;
   logic        mem_rd;
   logic [14:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] cycles;
   logic [63:0] watch_data;
   logic        watch_valid;

   int          n_assert;
   int          n_fail;
   logic [14:0] stop;

`ifdef RUNCTL_HALT_DETECT_EN
   localparam logic [63:0] EXP_HALT_TO  = 64'd0;
   localparam logic [63:0] EXP_HALT_CYC = 64'd8;
   localparam logic [63:0] EXP_TIE_TO   = 64'd0;
`else
   localparam logic [63:0] EXP_HALT_TO  = 64'd1;
   localparam logic [63:0] EXP_HALT_CYC = 64'd250;
   localparam logic [63:0] EXP_TIE_TO   = 64'd1;
`endif
   localparam logic [63:0] EXP_SNAP  = 64'h1234_0005_0003_0002;
   localparam logic [63:0] EXP_ADDRS = 64'h0000_0001_0002_0010;

   run_controller dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .pc          (pc),
      .cpu_reset   (cpu_reset),
      .cpu_run     (cpu_run),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .cycles      (cycles),
      .watch_data  (watch_data),
      .watch_valid (watch_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM contents after the test program: R0=2, R1=3, R2=R0+R1=5, R16=0x1234.
   function automatic logic [15:0] mem_word(input logic [14:0] a);
      case (a)
         15'd0:   return 16'd2;
         15'd1:   return 16'd3;
         15'd2:   return 16'd5;
         15'd16:  return 16'h1234;
         default: return 16'hDEAD;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: CPU pc model and registered RAM model, sampled 1 time unit
   // after the edge.
   task automatic step();
      logic        rd;
      logic [14:0] a;
      logic        run;
      logic        rs;
      rd  = mem_rd;
      a   = mem_addr;
      run = cpu_run;
      rs  = cpu_reset;
      @(posedge clock);
      #1;
      if (rd) mem_rdata = mem_word(a);
      if (run && rs) pc = '0;
      else if (run && !rs && pc != stop) pc = pc + 15'd1;
   endtask

   task automatic start_run(input string tag);
      int rc;
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " busy after start"}, 64'(busy), 64'd1);
      check({tag, " watch_valid cleared"}, 64'(watch_valid), 64'd0);
      check({tag, " done cleared"}, 64'(done), 64'd0);
      check({tag, " cycles cleared"}, 64'(cycles), 64'd0);
      check({tag, " cpu_run in reset"}, 64'(cpu_run), 64'd1);
      rc = 0;
      while (cpu_reset && rc < 20) begin
         rc++;
         step();
      end
      check({tag, " cpu_reset length"}, 64'(rc), 64'd4);
   endtask

   task automatic finish_run(input string tag, input bit start_in_dump,
                             input logic [63:0] exp_to, input logic [63:0] exp_cyc);
      int          n;
      int          k;
      int          rdc;
      logic [63:0] alog;
      n = 0;
      while (cpu_run && n < 400) begin
         step();
         n++;
      end
      check({tag, " run ended"}, 64'(cpu_run), 64'd0);
      k    = 1;
      rdc  = 0;
      alog = '0;
      if (mem_rd) begin
         rdc++;
         alog = {alog[47:0], 1'b0, mem_addr};
      end
      while (!done && k < 20) begin
         if (k == 1 && start_in_dump) start = 1'b1;
         step();
         start = 1'b0;
         k++;
         if (mem_rd) begin
            rdc++;
            alog = {alog[47:0], 1'b0, mem_addr};
         end
      end
      check({tag, " done latency"}, 64'(k), 64'd6);
      check({tag, " read count"}, 64'(rdc), 64'd4);
      check({tag, " read addrs"}, alog, EXP_ADDRS);
      check({tag, " watch_data"}, watch_data, EXP_SNAP);
      check({tag, " watch_valid"}, 64'(watch_valid), 64'd1);
      check({tag, " busy low"}, 64'(busy), 64'd0);
      check({tag, " cpu frozen"}, {62'd0, cpu_run, cpu_reset}, 64'd0);
      check({tag, " timeout"}, 64'(timeout), exp_to);
      check({tag, " cycles"}, 64'(cycles), exp_cyc);
   endtask

   initial begin
      int n;
      n_assert  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      start     = 1'b0;
      pc        = '0;
      stop      = 15'd5;
      mem_rdata = '0;
      step();
      step();

      check("rst cpu_reset", 64'(cpu_reset), 64'd1);
      check("rst cpu_run", 64'(cpu_run), 64'd0);
      check("rst mem_rd/addr", {48'd0, mem_rd, mem_addr}, 64'd0);
      check("rst busy/done/to/wv", {60'd0, busy, done, timeout, watch_valid}, 64'd0);
      check("rst cycles", 64'(cycles), 64'd0);
      check("rst watch_data", watch_data, 64'd0);

      reset = 1'b1;
      step();
      check("idle holds", {62'd0, cpu_reset, busy}, 64'd2);

      // Halting program, start pulsed during RUN and DUMP.
      stop = 15'd5;
      start_run("A");
      start = 1'b1;
      step();
      start = 1'b0;
      check("A start in run ignored", {62'd0, busy, cpu_reset}, 64'd2);
      check("A first run cycle", 64'(cycles), 64'd1);
      finish_run("A", 1'b1, EXP_HALT_TO, EXP_HALT_CYC);

      // Restart from DONE reproduces the same result.
      start_run("B");
      finish_run("B", 1'b0, EXP_HALT_TO, EXP_HALT_CYC);

      // Program never repeats pc: budget expires.
      stop = 15'h7FFF;
      start_run("C");
      finish_run("C", 1'b0, 64'd1, 64'd250);

      // Tight loop reached so halt and budget hit on the same edge.
      stop = 15'd247;
      start_run("D");
      finish_run("D", 1'b0, EXP_TIE_TO, 64'd250);

      // Reset mid-RUN.
      stop = 15'h7FFF;
      start_run("E");
      n = 0;
      while (cycles != 32'd37 && n < 100) begin
         step();
         n++;
      end
      check("E reached 37", 64'(cycles), 64'd37);
      reset = 1'b0;
      #1;
      check("E async cycles", 64'(cycles), 64'd0);
      check("E async cpu_reset", 64'(cpu_reset), 64'd1);
      check("E async busy", 64'(busy), 64'd0);
      step();
      check("E idle outputs", {60'd0, cpu_run, done, timeout, watch_valid}, 64'd0);
      check("E snapshot discarded", watch_data, 64'd0);
      reset = 1'b1;
      step();
      check("E stays idle", {62'd0, cpu_reset, busy}, 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run-control block for the Hack-style `Computer`. It puts the on-board CPU through a reset/run/halt sequence with parametrised reset length, cycle budget and halt detection. After the run it snapshots NWATCH data-memory words through a read port, giving hardware the same reset → run → inspect-RAM flow the simulation bench provides. It sits between the board clock domain and `Computer` and drives the CPU's reset and clock enable.

## Interface
- `ADDR_W`, 15: data-memory address width (RAM32K).
- `DATA_W`, 16: data word width.
- `PC_W`, 15: program counter width.
- `NWATCH`, 4: number of watched memory words, 1..16.
- `WATCH_ADDRS`, {15'd16,15'd2,15'd1,15'd0}: packed NWATCH×ADDR_W list; entry i is at bits [i*ADDR_W +: ADDR_W].
- `RESET_CYCLES`, 4: CPU reset hold length in cycles, ≥1.
- `MAX_CYCLES`, 250: RUN-cycle budget before timeout, ≥1.
- `HALT_WINDOW`, 3: consecutive cycles with unchanged `pc` that count as a halt, ≥2.

Ports:
- `clock`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low; all state clears while low.
- `start`  in  1  one-cycle request to begin a run.
- `pc`  in  PC_W  CPU program counter.
- `cpu_reset`  out  1  active-high reset to `Computer`.
- `cpu_run`  out  1  clock enable to `Computer`.
- `mem_rd`  out  1  read strobe.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd`.
- `busy`  out  1  high in RESET, RUN, DUMP.
- `done`  out  1  high in DONE.
- `timeout`  out  1  run ended on the cycle budget.
- `cycles`  out  32  RUN cycles executed, saturating.
- `watch_data`  out  NWATCH*DATA_W  snapshot; word i at [i*DATA_W +: DATA_W].
- `watch_valid`  out  1  snapshot complete.

## Operation
- Reset values: state IDLE, `cpu_reset`=1 (CPU held), `cpu_run`=0, `mem_rd`=0, `mem_addr`=0, `busy`=`done`=`timeout`=`watch_valid`=0, `cycles`=0, `watch_data`=0.
- IDLE: `cpu_reset`=1, `cpu_run`=0. On `start`, go to RESET and clear `cycles`, `timeout`, `watch_valid`, the stable counter and the reset counter.
- RESET: `cpu_reset`=1, `cpu_run`=1 for exactly RESET_CYCLES cycles, then go to RUN.
- RUN: `cpu_reset`=0, `cpu_run`=1. `cycles` increments each cycle and saturates at 2^32−1.
  - Stable counter: increments when `pc` equals the `pc` registered on the previous RUN cycle, otherwise clears. The first RUN cycle has no valid previous `pc` and counts as "changed".
  - Halt: stable counter reaches HALT_WINDOW−1. Timeout: `cycles` reaches MAX_CYCLES.
  - On halt or timeout, go to DUMP. `timeout`=1 only if timeout occurs without a simultaneous halt; halt wins a tie.
- DUMP: `cpu_run`=0, `cpu_reset`=0, so CPU state is frozen. Issues NWATCH reads on consecutive cycles, index 0..NWATCH−1. Each returned word is captured into slot i one cycle later. After the last capture, go to DONE.
- DONE: `done`=1, `watch_valid`=1, CPU stays frozen. `start` goes to RESET and behaves exactly as from IDLE.
- `start` is ignored in RESET, RUN and DUMP.
- `reset` low in any state returns to IDLE immediately. A partial snapshot is discarded.

## Timing
- `start` sampled at edge N → `cpu_reset`=1, `cpu_run`=1 from N+1 through N+RESET_CYCLES. First RUN cycle is N+RESET_CYCLES+1.
- `busy` rises the cycle after `start` and falls when DONE is entered.
- Halt/timeout detected at edge M → DUMP from M+1. `mem_rd` is high for cycles M+1..M+NWATCH. `done` and `watch_valid` rise at M+NWATCH+2.
- `cycles` is frozen from DUMP onward. A timeout run reports `cycles`=MAX_CYCLES.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `RUNCTL_HALT_DETECT_EN` defined: halt detection as above.
- Not defined: no stable counter is built. A run ends only on MAX_CYCLES, and `timeout`=1 always at DONE.

## Test plan
- Reset low mid-RUN with `cycles`=37 → next cycle IDLE, `cycles`=0, `cpu_reset`=1, `busy`=0.
- `start`, program loads R0=2, R1=3, R2=R0+R1, then loops `@END;0;JMP` → `cpu_reset` high for 4 cycles, halt detected, `timeout`=0, `watch_data` = {R16, 5, 3, 2}, `watch_valid` rises exactly NWATCH+2 cycles after detection.
- Program never repeats `pc`, MAX_CYCLES=250 → `timeout`=1, `cycles`=250, snapshot still taken.
- Halt and timeout on the same cycle (tight loop entered at cycle 249) → `timeout`=0.
- `start` pulsed during RUN and during DUMP → no effect. `start` in DONE → second run clears `watch_valid` the next cycle and reproduces identical results.
- Build without `RUNCTL_HALT_DETECT_EN`, halting program → runs the full 250 cycles, `timeout`=1.
